// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, X-stage redirect flushes, memory wait holds,
// a memory-wait watchdog with sticky fault, and saturating stall/flush statistics.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic        d_uses_rs,
  input  logic        d_uses_rt,
  input  logic        x_mem_read,
  input  logic [4:0]  x_dest_addr,
  input  logic        x_branch_taken,
  input  logic        x_jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        cnt_clr,
  output logic        pc_write,
  output logic        fd_write,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        dx_hold,
  output logic        xm_hold,
  output logic        fault,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FAULT    = 2'd2;

  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_next_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic w_load_use;
  logic w_redirect;
  logic w_mem_stall;
  logic w_active;
  logic w_stall_inc;
  logic w_flush_inc;

  // x_dest_addr == 0 is the hardwired zero register and never creates a dependency
  assign w_load_use = x_mem_read && (x_dest_addr != 5'd0) &&
                      ((d_uses_rs && (d_rs_addr == x_dest_addr)) ||
                       (d_uses_rt && (d_rt_addr == x_dest_addr)));
  assign w_redirect  = x_branch_taken | x_jump;
  assign w_mem_stall = mem_req & ~mem_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // Next-state logic; wait_cnt counts consecutive mem-stall cycles including the entry cycle
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_next_state    = S_MEM_WAIT;
          w_next_wait_cnt = 16'd1;
        end
      end
      S_MEM_WAIT: begin
        if (w_mem_stall) begin
          if (r_wait_cnt == TIMEOUT_LAST) begin
            w_next_state = S_FAULT;
          end else begin
            w_next_wait_cnt = r_wait_cnt + 16'd1;
          end
        end else begin
          w_next_state    = S_RUN;
          w_next_wait_cnt = 16'd0;
        end
      end
      S_FAULT: begin
        w_next_state = S_FAULT;
      end
      default: begin
        w_next_state    = S_RUN;
        w_next_wait_cnt = 16'd0;
      end
    endcase
  end

  // Output logic; rst forces the pipeline into a flushed, bubbling state without a clock edge
  always_comb begin
    pc_write  = 1'b1;
    fd_write  = 1'b1;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    dx_hold   = 1'b0;
    xm_hold   = 1'b0;
    fault     = 1'b0;
    if (rst) begin
      pc_write  = 1'b0;
      fd_write  = 1'b0;
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
    end else if (r_state == S_FAULT) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      dx_hold  = 1'b1;
      xm_hold  = 1'b1;
      fault    = 1'b1;
    end else if (w_mem_stall) begin
      pc_write = 1'b0;
      fd_write = 1'b0;
      dx_hold  = 1'b1;
      xm_hold  = 1'b1;
    end else if (w_redirect) begin
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_write  = 1'b0;
      fd_write  = 1'b0;
      dx_bubble = 1'b1;
    end
  end

  assign w_active    = (r_state != S_FAULT);
  assign w_stall_inc = w_active & ~pc_write;
  assign w_flush_inc = w_active & w_redirect & ~w_mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else if (cnt_clr) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

  a_hold_bubble_excl: assert property (@(posedge clk) disable iff (rst) !(dx_hold && dx_bubble));
  a_flush_writes:     assert property (@(posedge clk) disable iff (rst) (fd_flush |-> fd_write));

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed table-driven bench for pipeline_hazard_controller, plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        rst;
  logic [4:0]  d_rs_addr, d_rt_addr, x_dest_addr;
  logic        d_uses_rs, d_uses_rt, x_mem_read, x_branch_taken, x_jump;
  logic        mem_req, mem_ready, cnt_clr;
  logic        pc_write, fd_write, fd_flush, dx_bubble, dx_hold, xm_hold, fault;
  logic [15:0] stall_count, flush_count;

  pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .x_mem_read(x_mem_read), .x_dest_addr(x_dest_addr),
    .x_branch_taken(x_branch_taken), .x_jump(x_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .fd_write(fd_write), .fd_flush(fd_flush),
    .dx_bubble(dx_bubble), .dx_hold(dx_hold), .xm_hold(xm_hold),
    .fault(fault), .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mrd;
    logic [4:0] dst;
    logic       br, jmp, mreq, mrdy, clr;
    logic [5:0] exp;   // {pc_write, fd_write, fd_flush, dx_bubble, dx_hold, xm_hold}
  } vec_t;

  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_FLUSH = 6'b111100;
  localparam logic [5:0] O_HOLD  = 6'b000011;
  localparam logic [5:0] O_RST   = 6'b001100;

  vec_t tbl[13];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [5:0] w_outs;
  assign w_outs = {pc_write, fd_write, fd_flush, dx_bubble, dx_hold, xm_hold};

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic mrd, input logic [4:0] dst,
                              input logic br, input logic jmp, input logic mreq,
                              input logic mrdy, input logic clr, input logic [5:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd; v.dst = dst;
    v.br = br; v.jmp = jmp; v.mreq = mreq; v.mrdy = mrdy; v.clr = clr; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge; outputs are sampled 1 time unit later, well before the rising edge
  task automatic apply(input vec_t v);
    @(negedge clk);
    d_rs_addr = v.rs; d_rt_addr = v.rt; d_uses_rs = v.urs; d_uses_rt = v.urt;
    x_mem_read = v.mrd; x_dest_addr = v.dst; x_branch_taken = v.br; x_jump = v.jmp;
    mem_req = v.mreq; mem_ready = v.mrdy; cnt_clr = v.clr;
    #1;
  endtask

  vec_t idle, clr_v, stall_v, stall_jmp_v, ready_v, ready_jmp_v, lu_v, lu_clr_v, jmp_v;
  int   exp_stall, exp_flush;

  initial begin
    idle        = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, O_RUN);
    clr_v       = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, O_RUN);
    stall_v     = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, 0, O_HOLD);
    stall_jmp_v = mk(5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 1, 1, 0, 0, O_HOLD);
    ready_v     = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, 0, O_RUN);
    ready_jmp_v = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 0, O_FLUSH);
    lu_v        = mk(5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0, 0, 0, O_LU);
    lu_clr_v    = mk(5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0, 0, 1, O_LU);
    jmp_v       = mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0, O_FLUSH);

    //           rs     rt     urs urt mrd dst    br jmp mreq mrdy clr exp
    tbl[0]  = mk(5'd0,  5'd0,  0,  0,  0,  5'd0,  0, 0,  0,   0,   0,  O_RUN);
    tbl[1]  = mk(5'd5,  5'd2,  1,  1,  1,  5'd5,  0, 0,  0,   0,   0,  O_LU);
    tbl[2]  = mk(5'd0,  5'd0,  1,  1,  1,  5'd0,  0, 0,  0,   0,   0,  O_RUN);
    tbl[3]  = mk(5'd1,  5'd7,  1,  1,  1,  5'd7,  0, 0,  0,   0,   0,  O_LU);
    tbl[4]  = mk(5'd1,  5'd7,  1,  0,  1,  5'd7,  0, 0,  0,   0,   0,  O_RUN);
    tbl[5]  = mk(5'd7,  5'd7,  0,  0,  1,  5'd7,  0, 0,  0,   0,   0,  O_RUN);
    tbl[6]  = mk(5'd5,  5'd0,  1,  0,  0,  5'd5,  0, 0,  0,   0,   0,  O_RUN);
    tbl[7]  = mk(5'd5,  5'd0,  1,  0,  1,  5'd5,  1, 0,  0,   0,   0,  O_FLUSH);
    tbl[8]  = mk(5'd0,  5'd0,  0,  0,  0,  5'd0,  0, 1,  0,   0,   0,  O_FLUSH);
    tbl[9]  = mk(5'd0,  5'd0,  0,  0,  0,  5'd0,  0, 0,  1,   1,   0,  O_RUN);
    tbl[10] = mk(5'd4,  5'd0,  1,  0,  1,  5'd4,  1, 0,  1,   0,   0,  O_HOLD);
    tbl[11] = mk(5'd0,  5'd0,  0,  0,  0,  5'd0,  0, 1,  1,   1,   0,  O_FLUSH);
    tbl[12] = mk(5'd31, 5'd31, 1,  1,  1,  5'd31, 0, 0,  0,   0,   0,  O_LU);

    d_rs_addr = '0; d_rt_addr = '0; d_uses_rs = 0; d_uses_rt = 0; x_mem_read = 0;
    x_dest_addr = '0; x_branch_taken = 0; x_jump = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
    rst = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 32'(w_outs), 32'(O_RST));
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_stall_cnt", 32'(stall_count), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle vectors; counter totals follow from the expected outputs of the table
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      chk($sformatf("vec%0d_outs", i), 32'(w_outs), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'd0);
      if (tbl[i].exp[5] == 1'b0) exp_stall++;
      if (tbl[i].exp[3] == 1'b1) exp_flush++;
    end
    apply(idle);
    chk("tbl_stall_cnt", 32'(stall_count), 32'(exp_stall));
    chk("tbl_flush_cnt", 32'(flush_count), 32'(exp_flush));

    // Three-cycle memory wait with a redirect masked in the middle; ready lands on the timeout cycle
    apply(clr_v);
    apply(stall_v);      chk("mw1_outs", 32'(w_outs), 32'(O_HOLD));
    apply(stall_jmp_v);  chk("mw2_outs", 32'(w_outs), 32'(O_HOLD));
    apply(stall_v);      chk("mw3_outs", 32'(w_outs), 32'(O_HOLD));
    apply(ready_v);      chk("mw_ready_outs", 32'(w_outs), 32'(O_RUN));
    apply(idle);
    chk("mw_back_run", 32'(w_outs), 32'(O_RUN));
    chk("mw_no_fault", 32'(fault), 32'd0);
    chk("mw_stall_cnt", 32'(stall_count), 32'd3);
    chk("mw_flush_cnt", 32'(flush_count), 32'd0);

    // Watchdog timeout with MEM_TIMEOUT = 4
    apply(clr_v);
    for (int i = 0; i < 4; i++) begin
      apply(stall_v);
      chk($sformatf("to_wait%0d_fault", i), 32'(fault), 32'd0);
    end
    apply(ready_jmp_v);
    chk("to_fault_set", 32'(fault), 32'd1);
    chk("to_fault_outs", 32'(w_outs), 32'(O_HOLD));
    apply(lu_v);
    apply(idle);
    chk("to_fault_sticky", 32'(fault), 32'd1);
    chk("to_fault_hold_outs", 32'(w_outs), 32'(O_HOLD));
    chk("to_stall_frozen", 32'(stall_count), 32'd4);
    chk("to_flush_frozen", 32'(flush_count), 32'd0);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_outs", 32'(w_outs), 32'(O_RST));
    chk("arst_stall_cnt", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(idle);
    chk("post_rst_outs", 32'(w_outs), 32'(O_RUN));

    // Saturation, then clear coincident with a stall
    apply(jmp_v);
    apply(lu_v);
    repeat (65540) @(posedge clk);
    apply(lu_v);
    chk("sat_stall_cnt", 32'(stall_count), 32'h0000FFFF);
    chk("sat_flush_cnt", 32'(flush_count), 32'd1);
    apply(lu_clr_v);
    chk("clr_cycle_outs", 32'(w_outs), 32'(O_LU));
    apply(idle);
    chk("clr_stall_cnt", 32'(stall_count), 32'd0);
    chk("clr_flush_cnt", 32'(flush_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
